// File: rtl/mod14_seq_checker_if.sv
// Snoop/status bundle between a mod-14 up/down counter and its in-line sequence checker.
// The master side drives the counter controls it observes; the slave side is the checker.
interface mod14_seq_checker_if #(
    parameter int MODULUS    = 14,
    parameter int WIDTH      = 4,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 16
);
    logic                  ctr_clear;
    logic                  ctr_load;
    logic                  ctr_mode;
    logic [WIDTH-1:0]      ctr_data_in;
    logic [WIDTH-1:0]      ctr_data_out;
    logic                  chk_en;
    logic                  err_ack;

    logic [1:0]            state;
    logic [WIDTH-1:0]      expected;
    logic                  mismatch;
    logic                  range_err;
    logic                  err_sticky;
    logic [ERR_CNT_W-1:0]  err_count;
    logic                  wrap_up;
    logic                  wrap_dn;
    logic [WRAP_CNT_W-1:0] wrap_count;
    logic [MODULUS-1:0]    cov_bitmap;
    logic                  cov_full;

    modport master (
        output ctr_clear, ctr_load, ctr_mode, ctr_data_in, ctr_data_out, chk_en, err_ack,
        input  state, expected, mismatch, range_err, err_sticky, err_count,
               wrap_up, wrap_dn, wrap_count, cov_bitmap, cov_full
    );

    modport slave (
        input  ctr_clear, ctr_load, ctr_mode, ctr_data_in, ctr_data_out, chk_en, err_ack,
        output state, expected, mismatch, range_err, err_sticky, err_count,
               wrap_up, wrap_dn, wrap_count, cov_bitmap, cov_full
    );
endinterface

// File: rtl/mod14_seq_checker.sv
// Observational checker for a mod-14 up/down counter: predicts each count, flags deviations,
// counts wraps/errors. Optional value coverage is built when CHK_COVERAGE_EN is defined.
module mod14_seq_checker #(
    parameter int MODULUS    = 14,
    parameter int WIDTH      = 4,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    mod14_seq_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SYNC  = 2'b01,
        ST_TRACK = 2'b10,
        ST_ERROR = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_VAL = (WIDTH + 1)'(MODULUS);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      prev_q, prev_d;
    logic                  cmd_clear_q, cmd_clear_d;
    logic                  cmd_load_q, cmd_load_d;
    logic                  cmd_mode_q, cmd_mode_d;
    logic [WIDTH-1:0]      cmd_data_q, cmd_data_d;
    logic                  mismatch_q, mismatch_d;
    logic                  range_err_q, range_err_d;
    logic                  err_sticky_q, err_sticky_d;
    logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
    logic                  wrap_up_q, wrap_up_d;
    logic                  wrap_dn_q, wrap_dn_d;
    logic [WRAP_CNT_W-1:0] wrap_count_q, wrap_count_d;

    logic [WIDTH-1:0]      pred_value;
    logic                  check_active;
    logic                  obs_match;
    logic                  plain_step;
    logic                  new_error;
    logic [1:0]            err_inc;
    logic [ERR_CNT_W:0]    err_sum;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            cmd_clear_q  <= 1'b0;
            cmd_load_q   <= 1'b0;
            cmd_mode_q   <= 1'b0;
            cmd_data_q   <= '0;
            mismatch_q   <= 1'b0;
            range_err_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            wrap_up_q    <= 1'b0;
            wrap_dn_q    <= 1'b0;
            wrap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            cmd_clear_q  <= cmd_clear_d;
            cmd_load_q   <= cmd_load_d;
            cmd_mode_q   <= cmd_mode_d;
            cmd_data_q   <= cmd_data_d;
            mismatch_q   <= mismatch_d;
            range_err_q  <= range_err_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            wrap_up_q    <= wrap_up_d;
            wrap_dn_q    <= wrap_dn_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    // Next count the counter must produce from last cycle's value and command.
    always_comb begin
        pred_value = '0;
        if (cmd_clear_q) begin
            pred_value = '0;
        end else if (cmd_load_q) begin
            pred_value = cmd_data_q;
        end else if (cmd_mode_q) begin
            pred_value = (prev_q == TOP_VAL) ? '0 : prev_q + 1'b1;
        end else begin
            pred_value = (prev_q == '0) ? TOP_VAL : prev_q - 1'b1;
        end
    end

    always_comb begin
        check_active = bus.chk_en && ((state_q == ST_TRACK) || (state_q == ST_ERROR));
        obs_match    = (bus.ctr_data_out == pred_value);
        plain_step   = !cmd_clear_q && !cmd_load_q;

        prev_d      = bus.ctr_data_out;
        cmd_clear_d = bus.ctr_clear;
        cmd_load_d  = bus.ctr_load;
        cmd_mode_d  = bus.ctr_mode;
        cmd_data_d  = bus.ctr_data_in;

        mismatch_d  = check_active && !obs_match;
        range_err_d = check_active && ({1'b0, bus.ctr_data_out} >= MOD_VAL);
        new_error   = mismatch_d || range_err_d;

        // Wraps only count when the step was a genuine count, not a load or clear landing there.
        wrap_up_d = check_active && plain_step && cmd_mode_q  && (prev_q == TOP_VAL) && obs_match;
        wrap_dn_d = check_active && plain_step && !cmd_mode_q && (prev_q == '0)      && obs_match;

        err_inc     = {1'b0, mismatch_d} + {1'b0, range_err_d};
        err_sum     = {1'b0, err_count_q} + {{(ERR_CNT_W - 1){1'b0}}, err_inc};
        err_count_d = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];

        wrap_count_d = wrap_count_q + {{(WRAP_CNT_W - 1){1'b0}}, (wrap_up_d || wrap_dn_d)};

        err_sticky_d = err_sticky_q;
        if (new_error) begin
            err_sticky_d = 1'b1;
        end else if (bus.chk_en && bus.err_ack) begin
            err_sticky_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.chk_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_SYNC;
                ST_SYNC:  state_d = ST_TRACK;
                ST_TRACK: state_d = new_error ? ST_ERROR : ST_TRACK;
                // A fresh error in the acknowledge cycle keeps us in ERROR.
                ST_ERROR: state_d = new_error ? ST_ERROR : (bus.err_ack ? ST_TRACK : ST_ERROR);
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.state      = state_q;
    assign bus.expected   = (state_q == ST_IDLE) ? '0 : pred_value;
    assign bus.mismatch   = mismatch_q;
    assign bus.range_err  = range_err_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.err_count  = err_count_q;
    assign bus.wrap_up    = wrap_up_q;
    assign bus.wrap_dn    = wrap_dn_q;
    assign bus.wrap_count = wrap_count_q;

`ifdef CHK_COVERAGE_EN
    logic [MODULUS-1:0] cov_q;
    logic [MODULUS-1:0] cov_hit;

    for (genvar gi = 0; gi < MODULUS; gi++) begin : g_cov_hit
        assign cov_hit[gi] = check_active && (bus.ctr_data_out == WIDTH'(gi));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cov_q <= '0;
        end else begin
            cov_q <= cov_q | cov_hit;
        end
    end

    assign bus.cov_bitmap = cov_q;
    assign bus.cov_full   = &cov_q;
`else
    assign bus.cov_bitmap = '0;
    assign bus.cov_full   = 1'b0;
`endif

endmodule

// File: tb/tb_mod14_seq_checker.sv
// Directed + randomized bench for mod14_seq_checker; a virtual counter drives the snoop bus and
// an arithmetic reference model of the checking rules predicts every output each cycle.
module tb_mod14_seq_checker;

    logic clock;
    logic reset_n;

    mod14_seq_checker_if bus ();

    mod14_seq_checker dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state.
    int       m_state, m_prev, mc_din, m_err_cnt, m_wrap_cnt, ctr;
    bit       mc_clr, mc_ld, mc_md;
    bit       m_mis, m_rng, m_wup, m_wdn, m_sticky;
    bit [13:0] m_cov;

    function automatic int pred(int prev, bit clr, bit ld, bit md, int din);
        if (clr) return 0;
        if (ld)  return din;
        if (md)  return (prev == 13) ? 0 : (prev + 1) % 16;
        return (prev == 0) ? 13 : prev - 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit clr, input bit ld, input bit md, input int din, input int obs);
        int  exp;
        bit  act, en, ack;
        en  = bus.chk_en;
        ack = bus.err_ack;
        if (!reset_n) begin
            m_state = 0; m_prev = 0; mc_clr = 0; mc_ld = 0; mc_md = 0; mc_din = 0;
            m_mis = 0; m_rng = 0; m_wup = 0; m_wdn = 0; m_sticky = 0;
            m_err_cnt = 0; m_wrap_cnt = 0; m_cov = '0;
            return;
        end
        exp   = pred(m_prev, mc_clr, mc_ld, mc_md, mc_din);
        act   = en && (m_state == 2 || m_state == 3);
        m_mis = act && (obs != exp);
        m_rng = act && (obs >= 14);
        m_wup = act && !mc_clr && !mc_ld && mc_md  && (m_prev == 13) && (obs == exp);
        m_wdn = act && !mc_clr && !mc_ld && !mc_md && (m_prev == 0)  && (obs == exp);
        m_err_cnt  = m_err_cnt + int'(m_mis) + int'(m_rng);
        if (m_err_cnt > 255) m_err_cnt = 255;
        m_wrap_cnt = (m_wrap_cnt + int'(m_wup) + int'(m_wdn)) % 65536;
        if (m_mis || m_rng) m_sticky = 1;
        else if (en && ack) m_sticky = 0;
        if (!en) m_state = 0;
        else if (m_state == 0) m_state = 1;
        else if (m_state == 1) m_state = 2;
        else if (m_mis || m_rng) m_state = 3;
        else if (m_state == 3 && ack) m_state = 2;
        if (act && obs < 14) m_cov[obs] = 1'b1;
        m_prev = obs; mc_clr = clr; mc_ld = ld; mc_md = md; mc_din = din;
    endtask

    task automatic check_all();
        chk("state",      bus.state,      m_state);
        chk("expected",   bus.expected,   (m_state == 0) ? 0 : pred(m_prev, mc_clr, mc_ld, mc_md, mc_din));
        chk("mismatch",   bus.mismatch,   m_mis);
        chk("range_err",  bus.range_err,  m_rng);
        chk("err_sticky", bus.err_sticky, m_sticky);
        chk("err_count",  bus.err_count,  m_err_cnt);
        chk("wrap_up",    bus.wrap_up,    m_wup);
        chk("wrap_dn",    bus.wrap_dn,    m_wdn);
        chk("wrap_count", bus.wrap_count, m_wrap_cnt);
`ifdef CHK_COVERAGE_EN
        chk("cov_bitmap", bus.cov_bitmap, m_cov);
        chk("cov_full",   bus.cov_full,   &m_cov);
`else
        chk("cov_bitmap", bus.cov_bitmap, 0);
        chk("cov_full",   bus.cov_full,   0);
`endif
    endtask

    // One clock: present command and observed value (fault >= 0 overrides the counter), then check.
    task automatic cyc(input bit clr, input bit ld, input bit md, input int din, input int fault);
        int obs;
        @(negedge clock);
        obs = (fault >= 0) ? fault : ctr;
        bus.ctr_clear    = clr;
        bus.ctr_load     = ld;
        bus.ctr_mode     = md;
        bus.ctr_data_in  = 4'(din);
        bus.ctr_data_out = 4'(obs);
        @(posedge clock);
        model_step(clr, ld, md, din, obs);
        ctr = pred(obs, clr, ld, md, din);
        #1;
        check_all();
        $display("cyc t=%0t rst_n=%0b en=%0b ack=%0b cmd=%0b%0b%0b din=%0d obs=%0d state=%0d exp=%0d mis=%0b rng=%0b errs=%0d wraps=%0d",
                 $time, reset_n, bus.chk_en, bus.err_ack, clr, ld, md, din, obs,
                 bus.state, bus.expected, bus.mismatch, bus.range_err, bus.err_count, bus.wrap_count);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.chk_en  = 1'b1;
        bus.err_ack = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'(i), i, -1);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.ctr_clear = 0; bus.ctr_load = 0; bus.ctr_mode = 0;
        bus.ctr_data_in = '0; bus.ctr_data_out = '0;
        bus.chk_en = 1'b1; bus.err_ack = 1'b0;
        ctr = 7;

        // Reset with chk_en high, then IDLE -> SYNC -> TRACK.
        do_reset();
        chk("rst_state", bus.state, 0);
        chk("rst_errcnt", bus.err_count, 0);
        cyc(0, 1, 1, 12, -1);
        chk("to_sync", bus.state, 1);
        cyc(0, 0, 1, 0, -1);
        chk("to_track", bus.state, 2);

        // Up wrap: 12, 13, 0, 1.
        cyc(0, 0, 1, 0, -1);
        cyc(0, 0, 1, 0, -1);
        chk("upwrap_pulse", bus.wrap_up, 1);
        cyc(0, 0, 1, 0, -1);
        chk("upwrap_count", bus.wrap_count, 1);
        chk("upwrap_nomis", bus.err_count, 0);

        // Down wrap: clear, then 0 -> 13.
        cyc(1, 0, 0, 0, -1);
        cyc(0, 0, 0, 0, -1);
        cyc(0, 0, 0, 0, -1);
        chk("dnwrap_pulse", bus.wrap_dn, 1);
        chk("dnwrap_count", bus.wrap_count, 2);
        chk("dnwrap_errs", bus.err_count, 0);

        // Out of range: load 15, then up -> 15, 0.
        cyc(0, 1, 1, 15, -1);
        cyc(0, 0, 1, 0, -1);
        chk("oor_range", bus.range_err, 1);
        chk("oor_nomis", bus.mismatch, 0);
        cyc(0, 0, 1, 0, -1);
        chk("oor_quiet", bus.range_err | bus.mismatch, 0);
        chk("oor_errcnt", bus.err_count, 1);
        chk("oor_state", bus.state, 3);

        // Fault injection and acknowledge with a simultaneous new fault.
        do_reset();
        cyc(1, 0, 1, 0, -1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, -1);
        cyc(0, 0, 1, 0, 5);
        chk("fault_mis", bus.mismatch, 1);
        chk("fault_sticky", bus.err_sticky, 1);
        bus.err_ack = 1'b1;
        cyc(0, 0, 1, 0, 9);
        chk("ackfault_state", bus.state, 3);
        chk("ackfault_errcnt", bus.err_count, 2);
        cyc(0, 0, 1, 0, -1);
        chk("ack_state", bus.state, 2);
        chk("ack_sticky", bus.err_sticky, 0);
        bus.err_ack = 1'b0;

        // Coverage sweep: every legal value observed in TRACK.
        do_reset();
        cyc(1, 0, 1, 0, -1);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, -1);
`ifdef CHK_COVERAGE_EN
        chk("cov_sweep", bus.cov_full, 1);
`else
        chk("cov_sweep", bus.cov_full, 0);
`endif

        // err_count saturation: mismatch + range_err together every cycle.
        do_reset();
        cyc(1, 0, 0, 0, -1);
        cyc(1, 0, 0, 0, -1);
        for (int i = 0; i < 130; i++) cyc(1, 0, 0, 0, 15);
        chk("err_saturate", bus.err_count, 255);

        // Randomized traffic with gaps, acks, faults and mid-check resets.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int fv;
            reset_n     = ($urandom_range(0, 99) >= 2);
            bus.chk_en  = ($urandom_range(0, 29) != 0);
            bus.err_ack = ($urandom_range(0, 7) == 0);
            fv = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 15)) : -1;
            cyc(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), fv);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
